// File: rtl/video_scan_gen_if.sv
// Pixel-coordinate interface between the raster timing generator (master) and overlay/draw consumers.
// Carries frame_cnt only when SCAN_FRAME_CNT_EN is defined.
interface video_scan_gen_if;
  logic        pix_ce;
  logic [10:0] gr_x;
  logic [9:0]  gr_y;
  logic        en;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
`ifdef SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (input pix_ce, output gr_x, gr_y, en, hsync, vsync, line_start, frame_start, frame_cnt);
  modport slave  (output pix_ce, input gr_x, gr_y, en, hsync, vsync, line_start, frame_start, frame_cnt);
`else
  modport master (input pix_ce, output gr_x, gr_y, en, hsync, vsync, line_start, frame_start);
  modport slave  (output pix_ce, input gr_x, gr_y, en, hsync, vsync, line_start, frame_start);
`endif
endinterface

// File: rtl/video_scan_gen.sv
// Raster timing generator: walks active area plus blanking one pixel per pix_ce, driving coordinates,
// syncs and line/frame strobes. Define SCAN_FRAME_CNT_EN to add a 16-bit frame counter output.
module video_scan_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input logic              clk,
  input logic              reset,
  video_scan_gen_if.master bus
);
  localparam int unsigned HW         = 11;
  localparam int unsigned VW         = 10;
  localparam int unsigned HXW        = HW + 1;
  localparam int unsigned VXW        = VW + 1;
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_params
    $error("video_scan_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
  end

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [HW-1:0] r_gr_x;
  logic [VW-1:0] r_gr_y;
  logic          r_en;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_line_start;
  logic          r_frame_start;

  logic [HW-1:0] w_hcnt_nxt;
  logic [VW-1:0] w_vcnt_nxt;
  logic          w_h_wrap;
  logic          w_active;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_line_wrap;
  logic          w_frame_wrap;

  // Next raster position and the phase decode of that position, so outputs describe where we land.
  always_comb begin
    w_h_wrap   = (r_hcnt == HW'(H_TOTAL - 1));
    w_hcnt_nxt = w_h_wrap ? '0 : r_hcnt + HW'(1);
    w_vcnt_nxt = r_vcnt;
    if (w_h_wrap) begin
      w_vcnt_nxt = (r_vcnt == VW'(V_TOTAL - 1)) ? '0 : r_vcnt + VW'(1);
    end
    w_active     = ({1'b0, w_hcnt_nxt} < HXW'(H_ACTIVE)) && ({1'b0, w_vcnt_nxt} < VXW'(V_ACTIVE));
    w_h_sync     = ({1'b0, w_hcnt_nxt} >= HXW'(H_SYNC_BEG)) && ({1'b0, w_hcnt_nxt} < HXW'(H_SYNC_END));
    w_v_sync     = ({1'b0, w_vcnt_nxt} >= VXW'(V_SYNC_BEG)) && ({1'b0, w_vcnt_nxt} < VXW'(V_SYNC_END));
    w_line_wrap  = (w_hcnt_nxt == '0);
    w_frame_wrap = w_line_wrap && (w_vcnt_nxt == '0);
  end

  // Reset parks at the last blanking pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcnt        <= HW'(H_TOTAL - 1);
      r_vcnt        <= VW'(V_TOTAL - 1);
      r_gr_x        <= '0;
      r_gr_y        <= '0;
      r_en          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (bus.pix_ce) begin
        r_hcnt        <= w_hcnt_nxt;
        r_vcnt        <= w_vcnt_nxt;
        r_en          <= w_active;
        r_gr_x        <= w_active ? w_hcnt_nxt : '0;
        r_gr_y        <= w_active ? w_vcnt_nxt : '0;
        r_hsync       <= w_h_sync ? HS_POL : ~HS_POL;
        r_vsync       <= w_v_sync ? VS_POL : ~VS_POL;
        r_line_start  <= w_line_wrap;
        r_frame_start <= w_frame_wrap;
      end
    end
  end

  assign bus.gr_x        = r_gr_x;
  assign bus.gr_y        = r_gr_y;
  assign bus.en          = r_en;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

`ifdef SCAN_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts frame_start events; reads 1 throughout the first frame after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (bus.pix_ce && w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_video_scan_gen.sv
// Bench for video_scan_gen: a small-raster instance (inverted sync polarity) and a default instance,
// both checked every cycle against a linear-position reference model under random pix_ce.
`timescale 1ns/1ps
module tb_video_scan_gen;
  localparam int S_HA = 20, S_HFP = 3, S_HS = 5, S_HBP = 4;
  localparam int S_VA = 12, S_VFP = 2, S_VS = 3, S_VBP = 2;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
  localparam int S_FT = S_HT * S_VT;
  localparam int D_HA = 1024, D_HFP = 24, D_HS = 136, D_HBP = 160;
  localparam int D_VA = 768, D_VFP = 3, D_VS = 6, D_VBP = 29;
  localparam int D_HT = D_HA + D_HFP + D_HS + D_HBP;
  localparam int D_VT = D_VA + D_VFP + D_VS + D_VBP;
  localparam int D_FT = D_HT * D_VT;

  logic        clk = 1'b0;
  logic        reset;
  int          n_cmp = 0;
  int          n_err = 0;
  int          p_s;
  int          p_d;
  bit          st;
  logic [15:0] fc_s;

  video_scan_gen_if vif_s ();
  video_scan_gen_if vif_d ();

  video_scan_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (.clk(clk), .reset(reset), .bus(vif_s));

  video_scan_gen u_dflt (.clk(clk), .reset(reset), .bus(vif_d));

  always #5 clk = ~clk;

  // Position p counts pixels since frame origin; h/v and every output follow from plain arithmetic.
  function automatic logic [25:0] model(input int p, input bit stepped,
                                        input int ha, input int hfp, input int hs, input int hbp,
                                        input int va, input int vfp, input int vs, input bit hp, input bit vp);
    int ht;
    int h;
    int v;
    bit act;
    bit hin;
    bit vin;
    ht  = ha + hfp + hs + hbp;
    h   = p % ht;
    v   = p / ht;
    act = (h < ha) && (v < va);
    hin = (h >= ha + hfp) && (h < ha + hfp + hs);
    vin = (v >= va + vfp) && (v < va + vfp + vs);
    return {act ? 11'(h) : 11'd0, act ? 10'(v) : 10'd0, act,
            hin ? hp : ~hp, vin ? vp : ~vp, stepped && (h == 0), stepped && (p == 0)};
  endfunction

  function automatic logic [25:0] exp_s();
    return model(p_s, st, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, 1'b1, 1'b1);
  endfunction

  function automatic logic [25:0] exp_d();
    return model(p_d, st, D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, 1'b0, 1'b0);
  endfunction

  function automatic logic [25:0] obs_s();
    return {vif_s.gr_x, vif_s.gr_y, vif_s.en, vif_s.hsync, vif_s.vsync, vif_s.line_start, vif_s.frame_start};
  endfunction

  function automatic logic [25:0] obs_d();
    return {vif_d.gr_x, vif_d.gr_y, vif_d.en, vif_d.hsync, vif_d.vsync, vif_d.line_start, vif_d.frame_start};
  endfunction

  task automatic model_reset();
    p_s  = S_FT - 1;
    p_d  = D_FT - 1;
    st   = 1'b0;
    fc_s = 16'd0;
  endtask

  // One clock with the given enable; model advances on the same edge, outputs sampled 1ns later.
  task automatic tick(input bit ce);
    vif_s.pix_ce = ce;
    vif_d.pix_ce = ce;
    @(posedge clk);
    #1;
    if (ce) begin
      p_s = (p_s + 1) % S_FT;
      p_d = (p_d + 1) % D_FT;
      if (p_s == 0) fc_s = fc_s + 16'd1;
    end
    st = ce;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    vif_s.pix_ce = 1'b1;
    vif_d.pix_ce = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_s() !== exp_s()) begin n_err++; $display("FAIL reset_small got=%h exp=%h", obs_s(), exp_s()); end
    n_cmp++;
    if (obs_d() !== exp_d()) begin n_err++; $display("FAIL reset_dflt got=%h exp=%h", obs_d(), exp_d()); end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1);
      n_cmp++;
      if (obs_s() !== exp_s()) begin n_err++; $display("FAIL first_edge_small i=%0d got=%h exp=%h", i, obs_s(), exp_s()); end
      n_cmp++;
      if (obs_d() !== exp_d()) begin n_err++; $display("FAIL first_edge_dflt i=%0d got=%h exp=%h", i, obs_d(), exp_d()); end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 3) != 0);
      n_cmp++;
      if (obs_s() !== exp_s()) begin n_err++; $display("FAIL random_small p=%0d got=%h exp=%h", p_s, obs_s(), exp_s()); end
      n_cmp++;
      if (obs_d() !== exp_d()) begin n_err++; $display("FAIL random_dflt p=%0d got=%h exp=%h", p_d, obs_d(), exp_d()); end
    end
  endtask

  // Default raster: one full line between line_start pulses, hsync low for exactly H_SYNC clocks.
  task automatic test_line();
    int  n;
    int  low;
    int  extra;
    bit  found;
    n = 0; low = 0; extra = 0; found = 1'b0;
    while (!found && n < D_HT + 2) begin
      tick(1'b1);
      found = vif_d.line_start;
      n++;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL line_start_timeout got=0 exp=1"); end
    else begin
      for (int j = 1; j <= D_HT; j++) begin
        tick(1'b1);
        if (vif_d.hsync === 1'b0) low++;
        if (j < D_HT && vif_d.line_start === 1'b1) extra++;
        n_cmp++;
        if (obs_d() !== exp_d()) begin n_err++; $display("FAIL line_dflt p=%0d got=%h exp=%h", p_d, obs_d(), exp_d()); end
      end
      n_cmp++;
      if (low != D_HS) begin n_err++; $display("FAIL hsync_width got=%0d exp=%0d", low, D_HS); end
      n_cmp++;
      if (vif_d.line_start !== 1'b1 || extra != 0) begin
        n_err++; $display("FAIL line_period got=%b extra=%0d exp=1 extra=0", vif_d.line_start, extra);
      end
    end
  endtask

  // Small raster: a full frame between frame_start pulses with exact en and vsync counts.
  task automatic test_frame();
    int n;
    int en_cnt;
    int vs_cnt;
    bit found;
    n = 0; en_cnt = 0; vs_cnt = 0; found = 1'b0;
    while (!found && n < S_FT + 2) begin
      tick(1'b1);
      found = vif_s.frame_start;
      n++;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL frame_start_timeout got=0 exp=1"); end
    else begin
      if (vif_s.en === 1'b1) en_cnt++;
      if (vif_s.vsync === 1'b1) vs_cnt++;
      for (int j = 1; j <= S_FT; j++) begin
        tick(1'b1);
        if (j < S_FT && vif_s.en === 1'b1) en_cnt++;
        if (j < S_FT && vif_s.vsync === 1'b1) vs_cnt++;
        n_cmp++;
        if (obs_s() !== exp_s()) begin n_err++; $display("FAIL frame_small p=%0d got=%h exp=%h", p_s, obs_s(), exp_s()); end
      end
      n_cmp++;
      if (vif_s.frame_start !== 1'b1) begin n_err++; $display("FAIL frame_period got=%b exp=1", vif_s.frame_start); end
      n_cmp++;
      if (en_cnt != S_HA * S_VA) begin n_err++; $display("FAIL en_count got=%0d exp=%0d", en_cnt, S_HA * S_VA); end
      n_cmp++;
      if (vs_cnt != S_VS * S_HT) begin n_err++; $display("FAIL vsync_count got=%0d exp=%0d", vs_cnt, S_VS * S_HT); end
    end
  endtask

  // Alternating pix_ce doubles the line period; frozen outputs are checked by the model every cycle.
  task automatic test_ce_toggle();
    bit ce;
    bit found;
    int n;
    ce = 1'b1; found = 1'b0; n = 0;
    while (!found && n < 2 * S_HT + 4) begin
      tick(ce);
      found = vif_s.line_start;
      ce = ~ce;
      n++;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL toggle_sync_timeout got=0 exp=1"); end
    else begin
      n = 0; found = 1'b0;
      while (!found && n < 2 * S_HT + 4) begin
        tick(ce);
        ce = ~ce;
        n++;
        found = vif_s.line_start;
        n_cmp++;
        if (obs_s() !== exp_s()) begin n_err++; $display("FAIL toggle_small p=%0d got=%h exp=%h", p_s, obs_s(), exp_s()); end
        n_cmp++;
        if (obs_d() !== exp_d()) begin n_err++; $display("FAIL toggle_dflt p=%0d got=%h exp=%h", p_d, obs_d(), exp_d()); end
      end
      n_cmp++;
      if (n != 2 * S_HT) begin n_err++; $display("FAIL toggle_period got=%0d exp=%0d", n, 2 * S_HT); end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (p_s != 5 * S_HT + 10 && n < S_FT + 1) begin
      tick(1'b1);
      n++;
    end
    n_cmp++;
    if (p_s != 5 * S_HT + 10) begin n_err++; $display("FAIL mid_reset_seek got=%0d exp=%0d", p_s, 5 * S_HT + 10); end
    n_cmp++;
    if (vif_s.gr_x !== 11'd10 || vif_s.gr_y !== 10'd5) begin
      n_err++; $display("FAIL mid_pos got=(%0d,%0d) exp=(10,5)", vif_s.gr_x, vif_s.gr_y);
    end
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (obs_s() !== exp_s()) begin n_err++; $display("FAIL async_reset_small got=%h exp=%h", obs_s(), exp_s()); end
    n_cmp++;
    if (obs_d() !== exp_d()) begin n_err++; $display("FAIL async_reset_dflt got=%h exp=%h", obs_d(), exp_d()); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2 * S_HT; i++) begin
      tick(1'b1);
      n_cmp++;
      if (obs_s() !== exp_s()) begin n_err++; $display("FAIL restart_small p=%0d got=%h exp=%h", p_s, obs_s(), exp_s()); end
      n_cmp++;
      if (obs_d() !== exp_d()) begin n_err++; $display("FAIL restart_dflt p=%0d got=%h exp=%h", p_d, obs_d(), exp_d()); end
    end
  endtask

`ifdef SCAN_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int seen;
    seen = 0;
    for (int i = 0; i < 3 * S_FT + 2 && seen < 3; i++) begin
      tick(1'b1);
      if (vif_s.frame_start === 1'b1) begin
        seen++;
        n_cmp++;
        if (vif_s.frame_cnt !== fc_s) begin n_err++; $display("FAIL frame_cnt got=%0d exp=%0d", vif_s.frame_cnt, fc_s); end
      end
    end
    n_cmp++;
    if (seen != 3) begin n_err++; $display("FAIL frame_cnt_pulses got=%0d exp=3", seen); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    vif_s.pix_ce = 1'b0;
    vif_d.pix_ce = 1'b0;
    model_reset();
    test_reset();
    test_random(2000);
    test_line();
    test_frame();
    test_ce_toggle();
    test_mid_reset();
`ifdef SCAN_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
